// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory stall controller:
// FSM encoding, access-size codes and the default response timeout.
package mem_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam int unsigned TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mem_stall_ctrl_lane_fmt.sv
// Byte-lane formatting: derives the lane enables from size/offset and
// replicates right-aligned store data across the active lanes.
module mem_lane_fmt
    import mem_stall_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    // Lane enable and data replication per access size; code 11 acts as word.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_HALF: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            MEM_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory handshake controller: issues one request per
// load/store, stalls the pipeline until ack, and latches a sticky timeout.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_r_MEM,
    input  logic        mem_w_MEM,
    input  logic [2:0]  u_b_h_w_MEM,
    input  logic [31:0] addr_MEM,
    input  logic [31:0] wdata_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_req,
    output logic [31:0] rdata_MEM,
    output logic        rdata_valid,
    output logic        mem_err
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic               stall_s;
    logic               op_s;
    logic [3:0]         lane_be_s;
    logic [31:0]        lane_wdata_s;
    logic               unused_sign_s;

    // The signedness flag only matters to the load extender downstream.
    assign unused_sign_s = u_b_h_w_MEM[2];
    assign op_s          = mem_r_MEM | mem_w_MEM;

    mem_lane_fmt u_lane_fmt (
        .size_i    (u_b_h_w_MEM[1:0]),
        .addr_lo_i (addr_MEM[1:0]),
        .wdata_i   (wdata_MEM),
        .be_o      (lane_be_s),
        .wdata_o   (lane_wdata_s)
    );

    // Next-state, request capture and combinational stall decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        stall_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_s) begin
                    stall_s = 1'b1;
                    state_d = ST_REQ;
                    cnt_d   = {CNT_W{1'b0}};
                    req_d   = 1'b1;
                    we_d    = mem_w_MEM;
                    addr_d  = {addr_MEM[31:2], 2'b00};
                    be_d    = lane_be_s;
                    wdata_d = lane_wdata_s;
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                // Ack on the final allowed cycle still completes normally.
                if (dmem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d  = dmem_rdata;
                        rvalid_d = 1'b1;
                    end else begin
                        rdata_d  = rdata_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ERR;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                stall_s = 1'b1;
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0000_0000;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign stall_req   = stall_s;
    assign rdata_MEM   = rdata_q;
    assign rdata_valid = rvalid_q;
    assign mem_err     = err_q;

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, SHALL set the max REQ-state cycles without dmem_ack before the error state.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_r_MEM  input  1  load in MEM stage.
REQ-005 mem_w_MEM  input  1  store in MEM stage.
REQ-006 u_b_h_w_MEM  input  3  access size: [1:0] 00 byte, 01 half, 10 word; [2] unsigned flag (ignored here).
REQ-007 addr_MEM  input  32  byte address.
REQ-008 wdata_MEM  input  32  store data, right-aligned.
REQ-009 dmem_req  output  1  request to data memory.
REQ-010 dmem_we  output  1  1 write, 0 read.
REQ-011 dmem_addr  output  32  word-aligned address, {addr_MEM[31:2],2'b00}.
REQ-012 dmem_be  output  4  byte-lane enables.
REQ-013 dmem_wdata  output  32  lane-replicated store data.
REQ-014 dmem_ack  input  1  memory completion, one-cycle pulse.
REQ-015 dmem_rdata  input  32  read word, valid with dmem_ack.
REQ-016 stall_req  output  1  to hazard unit: hold PC/FD/DE/EM, bubble MW.
REQ-017 rdata_MEM  output  32  captured raw read word.
REQ-018 rdata_valid  output  1  rdata_MEM valid for the MEM-stage load.
REQ-019 mem_err  output  1  sticky timeout error.

Function
REQ-020 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-021 IDLE: mem_r_MEM|mem_w_MEM -> REQ; otherwise stay.
REQ-022 REQ: dmem_ack -> DONE; no ack and timeout count == TIMEOUT_CYC-1 -> ERR; otherwise stay.
REQ-023 DONE SHALL unconditionally go to IDLE after one cycle; ERR SHALL be held until reset.
REQ-024 stall_req SHALL be combinational: 1 in IDLE with mem_r_MEM|mem_w_MEM, 1 in REQ and ERR, 0 in DONE and idle IDLE.
REQ-025 On IDLE->REQ, dmem_we/addr/be/wdata SHALL be registered, dmem_req set to 1, and all held stable until ack.
REQ-026 dmem_req SHALL drop on the edge leaving REQ (to DONE or ERR).
REQ-027 mem_r_MEM and mem_w_MEM both 1: treat as write; rdata_valid SHALL stay 0.
REQ-028 dmem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111; code 11 treated as word.
REQ-029 dmem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-030 On ack of a read, dmem_rdata SHALL be captured into rdata_MEM; rdata_valid = 1 only in DONE after a read.
REQ-031 rdata_MEM SHALL hold its value until the next read ack.
REQ-032 Timeout counter SHALL clear on entering REQ and increment each REQ cycle without ack; ack on the timeout cycle SHALL win (-> DONE).
REQ-033 mem_err SHALL set on entry to ERR and stay 1 until reset.
REQ-034 Zero-wait ack (first REQ cycle) SHALL give stall_req high exactly 2 cycles, then DONE.
REQ-035 In DONE, MEM inputs still show the completed op and SHALL NOT start a new request; back-to-back ops start from the following IDLE.
REQ-036 dmem_ack outside REQ SHALL be ignored.

Reset
REQ-037 rst_n low SHALL immediately force IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, rdata_MEM, rdata_valid, mem_err, and the counter to 0.
REQ-038 Reset mid-REQ SHALL abort the transaction (dmem_req 0 without waiting for ack); a later stray ack is ignored per REQ-036.

Structure
REQ-039 Shared package SHALL hold state encoding, access-size codes (MEM_BYTE/MEM_HALF/MEM_WORD), and the TIMEOUT_CYC default.
REQ-040 Lane formatting (be + wdata replication) SHALL be a combinational sub-module mem_lane_fmt.

Verification
REQ-041 Load word addr 0x100, ack 3 cycles after dmem_req, rdata 0xDEADBEEF -> stall_req 4 cycles, dmem_req 3 cycles, DONE rdata_MEM=0xDEADBEEF, rdata_valid=1 for 1 cycle.
REQ-042 Store byte addr 0x203, wdata 0x000000A5, zero-wait ack -> dmem_be=4'b1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x200, stall 2 cycles, rdata_valid 0.
REQ-043 No ack, TIMEOUT_CYC=16 -> ERR after 16 REQ cycles, dmem_req 0, mem_err=1, stall_req stuck 1 until rst_n.
REQ-044 Ack exactly on 16th REQ cycle -> DONE, mem_err=0.
REQ-045 rst_n low in 2nd REQ cycle, ack pulse after release -> dmem_req falls asynchronously, state IDLE, ack ignored, all outputs 0.
REQ-046 Back-to-back load half 0x302 then store word 0x400 -> dmem_be 4'b1100 then 4'b1111; second dmem_req rises the cycle after DONE, no duplicate request.
